// File: rtl/seq_divider_24by12.sv
// -----------------------------------------------------------------------------
// seq_divider_24by12
//   Iterative radix-2 restoring unsigned divider. It divides a 2*width-bit
//   dividend by a width-bit divisor and produces one quotient bit per clock.
//   A division accepted at edge k completes at edge k+2*width. A zero divisor
//   completes at edge k+1 and flags div_by_zero.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   start        request; sampled only while idle
//   dividend     2*width-bit unsigned dividend, captured on accept
//   divisor      width-bit unsigned divisor, captured on accept
//   busy         high while a division is in progress
//   done         one-cycle pulse: quotient/remainder/div_by_zero valid
//   quotient     2*width-bit quotient (registered, held until next done)
//   remainder    width-bit remainder (registered, held until next done)
//   div_by_zero  set with done when the captured divisor was 0
// -----------------------------------------------------------------------------
module seq_divider_24by12 #(
   parameter int width = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2*width-1:0]   dividend,
   input  logic [width-1:0]     divisor,
   output logic                 busy,
   output logic                 done,
   output logic [2*width-1:0]   quotient,
   output logic [width-1:0]     remainder,
   output logic                 div_by_zero
);

   localparam int CNT_W = $clog2(2*width);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_ZERO
   } state_t;

   state_t               state_q;
   logic [width:0]       prem_q;      // partial remainder
   logic [2*width-1:0]   quo_q;       // dividend shifts out, quotient shifts in
   logic [width-1:0]     dvs_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 dbz_q;
   logic [2*width-1:0]   quotient_q;
   logic [width-1:0]     remainder_q;

   // One restoring step. The shifted value carries one extra guard bit so the
   // borrow of the trial subtraction lands in the MSB and gives the sign.
   logic [width+1:0]     shift_rem;
   logic [width+1:0]     trial;
   logic                 q_bit;
   logic [width:0]       prem_d;
   logic [2*width-1:0]   quo_d;

   // NOTE: every signal driven here gets a value on every path, so no latch
   // can be inferred; combinational logic uses blocking assignments.
   always_comb begin
      shift_rem = {prem_q, quo_q[2*width-1]};
      trial     = shift_rem - {2'b00, dvs_q};
      q_bit     = ~trial[width+1];
      prem_d    = q_bit ? trial[width:0] : shift_rem[width:0];
      quo_d     = {quo_q[2*width-2:0], q_bit};
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         prem_q      <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  quo_q   <= dividend;
                  dvs_q   <= divisor;
                  prem_q  <= '0;
                  cnt_q   <= CNT_W'(2*width-1);
                  busy_q  <= 1'b1;
                  dbz_q   <= 1'b0;
                  state_q <= (divisor == '0) ? S_ZERO : S_RUN;
               end
            end

            S_RUN: begin
               prem_q <= prem_d;
               quo_q  <= quo_d;
               cnt_q  <= cnt_q - CNT_W'(1);
               // The step taken with cnt_q==0 produces the last quotient bit,
               // so results are loaded straight from the next-state values.
               if (cnt_q == '0) begin
                  quotient_q  <= quo_d;
                  remainder_q <= prem_d[width-1:0];
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end

            S_ZERO: begin
               // Quotient saturates; remainder is the low half of the dividend.
               quotient_q  <= '1;
               remainder_q <= quo_q[width-1:0];
               dbz_q       <= 1'b1;
               done_q      <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_24by12.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_24by12
//   Self-checking bench for seq_divider_24by12: a table of directed vectors,
//   a multiplier round-trip loop, and hand-written handshake/reset sequences.
// -----------------------------------------------------------------------------
module tb_seq_divider_24by12;

   localparam int W       = 12;
   localparam int LAT     = 2*W;
   localparam int BUDGET  = 100;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [2*W-1:0]  dividend;
   logic [W-1:0]    divisor;
   logic            busy;
   logic            done;
   logic [2*W-1:0]  quotient;
   logic [W-1:0]    remainder;
   logic            div_by_zero;

   int n_checks = 0;
   int n_errors = 0;

   seq_divider_24by12 #(.width(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic [2*W-1:0]  dvd;
      logic [W-1:0]    dvs;
      logic [2*W-1:0]  exp_q;
      logic [W-1:0]    exp_r;
      logic            exp_dbz;
      int              exp_lat;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Outputs are sampled and inputs driven 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
      dividend = dvd;
      divisor  = dvs;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Counts edges from the accept edge until done is seen (bounded).
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < BUDGET) begin
         tick();
         lat++;
      end
   endtask

   int                lat;
   int                done_seen;
   logic [2*W-1:0]    prev_q;
   int unsigned       a, b, c;
   logic [2*W-1:0]    dvd;
   logic [W-1:0]      dvs;

   initial begin
      vecs[0] = '{"basic",   24'd1000000, 12'd999,   24'd1001,   12'd1,     1'b0, LAT};
      vecs[1] = '{"max_by1", 24'hFFFFFF,  12'h001,   24'hFFFFFF, 12'h000,   1'b0, LAT};
      vecs[2] = '{"max_max", 24'hFFFFFF,  12'hFFF,   24'h001001, 12'h000,   1'b0, LAT};
      vecs[3] = '{"zero_dd", 24'h000000,  12'h7A5,   24'h000000, 12'h000,   1'b0, LAT};
      vecs[4] = '{"div0",    24'h000ABC,  12'h000,   24'hFFFFFF, 12'hABC,   1'b1, 1};

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) tick();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_quot", 32'(quotient), 32'd0);
      check("reset_rem",  32'(remainder), 32'd0);
      check("reset_dbz",  32'(div_by_zero), 32'd0);
      rst = 1'b0;
      tick();

      // ---------------- directed table ----------------
      prev_q = '0;
      for (int i = 0; i < 5; i++) begin
         start_op(vecs[i].dvd, vecs[i].dvs);
         check({vecs[i].name, "_busy"},   32'(busy), 32'd1);
         check({vecs[i].name, "_hold"},   32'(quotient), 32'(prev_q));
         wait_done(lat);
         check({vecs[i].name, "_lat"},    32'(lat), 32'(vecs[i].exp_lat));
         check({vecs[i].name, "_quot"},   32'(quotient), 32'(vecs[i].exp_q));
         check({vecs[i].name, "_rem"},    32'(remainder), 32'(vecs[i].exp_r));
         check({vecs[i].name, "_dbz"},    32'(div_by_zero), 32'(vecs[i].exp_dbz));
         check({vecs[i].name, "_nbusy"},  32'(busy), 32'd0);
         tick();
         check({vecs[i].name, "_pulse"},  32'(done), 32'd0);
         tick();
         check({vecs[i].name, "_keepq"},  32'(quotient), 32'(vecs[i].exp_q));
         prev_q = vecs[i].exp_q;
      end

      // ---------------- multiplier round trip ----------------
      for (int i = 0; i < 50; i++) begin
         a   = $urandom_range(1, 4095);
         b   = $urandom_range(1, 4095);
         c   = $urandom_range(0, b - 1);
         dvd = 24'(a * b + c);
         dvs = 12'(b);
         start_op(dvd, dvs);
         wait_done(lat);
         check($sformatf("rt%0d_lat", i),  32'(lat), 32'(LAT));
         check($sformatf("rt%0d_quot", i), 32'(quotient), 32'(a));
         check($sformatf("rt%0d_rem", i),  32'(remainder), 32'(c));
         tick();
      end

      // ---------------- start while busy is ignored ----------------
      start_op(24'd1000000, 12'd999);
      repeat (4) tick();
      dividend = 24'hFFFFFF;
      divisor  = 12'h001;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      check("ign_busy", 32'(busy), 32'd1);
      wait_done(lat);
      check("ign_lat",  32'(lat + 5), 32'(LAT));
      check("ign_quot", 32'(quotient), 32'd1001);
      check("ign_rem",  32'(remainder), 32'd1);

      // ---------------- start in the done cycle (back to back) ----------------
      start_op(24'hFFFFFF, 12'hFFF);
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_hold", 32'(quotient), 32'd1001);
      wait_done(lat);
      check("b2b_lat",  32'(lat), 32'(LAT));
      check("b2b_quot", 32'(quotient), 32'h001001);
      check("b2b_rem",  32'(remainder), 32'h000);
      tick();

      // ---------------- reset mid-operation ----------------
      start_op(24'd1000000, 12'd999);
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rmid_busy", 32'(busy), 32'd0);
      check("rmid_done", 32'(done), 32'd0);
      check("rmid_quot", 32'(quotient), 32'd0);
      check("rmid_rem",  32'(remainder), 32'd0);
      done_seen = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done) done_seen++;
      end
      check("rmid_nodone", 32'(done_seen), 32'd0);

      start_op(24'd100, 12'd7);
      wait_done(lat);
      check("post_lat",  32'(lat), 32'(LAT));
      check("post_quot", 32'(quotient), 32'd14);
      check("post_rem",  32'(remainder), 32'd2);
      check("post_dbz",  32'(div_by_zero), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
